mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data RAM between two requesters: the IF stage (instruction fetch) and the MEM stage (lw/sw).
- Sequences each fixed-latency RAM access and generates the pipeline stall and flush controls.
- Sits beside the hazard detection unit. Its hold outputs are ORed with that unit's hold outputs before they reach the PC and the pipeline registers.

Parameters:
- LATENCY, 2: RAM access latency in cycles; must be at least 1. The command is held stable for LATENCY cycles.
- LAT_W, 3: width of the latency down-counter; must satisfy 2^LAT_W > LATENCY.
- ADDR_W, 32: byte-address width.
- MAX_STREAK, 4: maximum number of consecutive MEM grants while IF waits. Used only with MEM_ARB_FAIR_EN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ifReq  input  1  IF stage requests an instruction read
- ifAddr  input  ADDR_W  fetch address (the PC)
- ifRdata  output  32  instruction; valid while ifAck=1
- ifAck  output  1  fetch completes this cycle
- memRead  input  1  MEM stage executing lw
- memWrite  input  1  MEM stage executing sw
- memAddr  input  ADDR_W  data address
- memWdata  input  32  store data
- memRdata  output  32  load data; valid while memAck=1
- memAck  output  1  data access completes this cycle
- ramEn  output  1  RAM command valid
- ramWe  output  1  RAM write enable
- ramAddr  output  ADDR_W  RAM address
- ramWdata  output  32  RAM write data
- ramRdata  input  32  RAM read data; valid in the last cycle of the access
- pcHOLD  output  1  freeze the PC
- IFIDRegHOLD  output  1  freeze the IF/ID register
- IFflush  output  1  load a nop into IF/ID
- pipeHOLD  output  1  freeze the ID/EX, EX/MEM and MEM/WB registers

Behaviour:
- States:
  - IDLE: no access in progress.
  - BUSY_MEM: data access in progress.
  - BUSY_IF: fetch access in progress.
- Reset:
  - Asynchronous; forces state to IDLE and clears the counter, all latched command registers and the streak counter.
  - While rst is high, all outputs are 0.
  - A reset asserted mid-access aborts the access. No ack is produced and ramEn drops immediately.
- Arbitration in IDLE:
  - memReq is defined as memRead|memWrite.
  - If memReq is 1: latch memAddr, memWdata and memWrite; go to BUSY_MEM; counter = LATENCY-1.
  - Else if ifReq is 1: latch ifAddr; go to BUSY_IF; counter = LATENCY-1.
  - Else: stay in IDLE.
  - MEM has fixed priority because it belongs to the older instruction.
- In BUSY_x:
  - ramEn=1, and ramAddr/ramWdata come from the latched values.
  - ramWe=1 for every BUSY_MEM cycle of a store; ramWe=0 otherwise.
  - The counter decrements each cycle.
  - When counter==0: the matching ack is 1 combinationally, rdata = ramRdata, and the next state is IDLE.
- Timing:
  - A request first seen in cycle t gets its ack in cycle t+LATENCY.
  - Request inputs and address inputs are ignored while busy.
  - IDLE always costs one arbitration cycle between accesses.
- Outside BUSY_x: ramEn=0, ramWe=0, and ramAddr/ramWdata hold their last latched values.
- Simultaneous memRead and memWrite is illegal. It is treated as a write, and the bench flags it.
- Ack outputs:
  - ifAck and memAck are never both 1.
  - ifRdata and memRdata are 0 when their ack is 0.
- Stall outputs:
  - pipeHOLD = memReq & ~memAck.
  - pcHOLD = IFIDRegHOLD = pipeHOLD | (ifReq & ~ifAck).
  - IFflush = (ifReq & ~ifAck) & ~pipeHOLD. This inserts a bubble when the back end advances but the fetch has not returned.
- All stall outputs are combinational from the current state and the current inputs. There is no combinational path from ramRdata to any stall output.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- With the macro defined:
  - A streak counter increments on each MEM grant made while ifReq=1.
  - The streak counter clears on an IF grant or when ifReq=0.
  - When the streak counter equals MAX_STREAK, the next IDLE arbitration grants IF even if memReq=1.
- Without the macro: strict MEM priority, no streak counter logic, and MAX_STREAK is unused.

Test Plan:
- LATENCY=2, only ifReq=1 with ifAddr=0x40, RAM returns 0x8C010004 -> BUSY_IF for 2 cycles; ifAck=1 and ifRdata=0x8C010004 in cycle 2; pcHOLD=1 in cycles 0-1; IFflush=1 in cycles 0-1.
- ifReq=1 and memRead=1 (memAddr=0x100) in the same cycle -> MEM granted first; memAck at t+2; IF granted at t+3; ifAck at t+5; pipeHOLD=1 only in cycles t..t+1.
- memWrite=1, memAddr=0x200, memWdata=0xDEADBEEF -> ramWe=1, ramAddr=0x200, ramWdata=0xDEADBEEF for 2 cycles; memAck at t+2; memRdata=0.
- rst pulsed in the first BUSY_MEM cycle -> outputs 0 immediately; no memAck; state IDLE; memRead still high afterwards starts a fresh 2-cycle access.
- LATENCY=1 build, back-to-back lw pair -> each ack one cycle after its grant; one IDLE cycle between the accesses.
- MEM_ARB_FAIR_EN, MAX_STREAK=4, memRead and ifReq held high -> 4 MEM grants, then 1 IF grant, then MEM grants resume.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM command bundle of the shared memory port.
// slave = arbiter side, master = requesters, RAM and hazard logic side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              ifReq;
   logic [ADDR_W-1:0] ifAddr;
   logic [31:0]       ifRdata;
   logic              ifAck;
   logic              memRead;
   logic              memWrite;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memWdata;
   logic [31:0]       memRdata;
   logic              memAck;
   logic              ramEn;
   logic              ramWe;
   logic [ADDR_W-1:0] ramAddr;
   logic [31:0]       ramWdata;
   logic [31:0]       ramRdata;
   logic              pcHOLD;
   logic              IFIDRegHOLD;
   logic              IFflush;
   logic              pipeHOLD;

   modport slave (
      input  ifReq, ifAddr,
      input  memRead, memWrite,
      input  memAddr, memWdata,
      input  ramRdata,
      output ifRdata, ifAck,
      output memRdata, memAck,
      output ramEn, ramWe,
      output ramAddr, ramWdata,
      output pcHOLD, IFIDRegHOLD,
      output IFflush, pipeHOLD
   );

   modport master (
      output ifReq, ifAddr,
      output memRead, memWrite,
      output memAddr, memWdata,
      output ramRdata,
      input  ifRdata, ifAck,
      input  memRdata, memAck,
      input  ramEn, ramWe,
      input  ramAddr, ramWdata,
      input  pcHOLD, IFIDRegHOLD,
      input  IFflush, pipeHOLD
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for one single-ported RAM with pipeline stall controls.
// Define MEM_ARB_FAIR_EN to bound MEM grant streaks while IF waits.
module mem_port_arbiter #(
   parameter int LATENCY    = 2,
   parameter int LAT_W      = 3,
   parameter int ADDR_W     = 32,
   parameter int MAX_STREAK = 4
) (
   input logic clk,
   input logic rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_MEM,
      BUSY_IF
   } state_t;

   state_t            state_q, state_d;
   logic [LAT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;

   logic mem_req, fair_if;
   logic go_mem, go_if, done;
   logic live, busy_mem, busy_if;
   logic mem_ack, if_ack;
   logic pipe_hold, if_wait;

   if (LATENCY < 1 || (2 ** LAT_W) <= LATENCY ||
       MAX_STREAK < 1) begin : g_cfg_bad
      $error("mem_port_arbiter: bad parameters");
   end

   assign mem_req = bus.memRead | bus.memWrite;
   assign done    = (cnt_q == '0);
   assign go_mem  = (state_q == IDLE) & mem_req & ~fair_if;
   assign go_if   = (state_q == IDLE) & bus.ifReq & ~go_mem;

`ifdef MEM_ARB_FAIR_EN
   localparam int STK_W = $clog2(MAX_STREAK + 1);

   logic [STK_W-1:0] streak_q, streak_d;

   assign fair_if = bus.ifReq &
                    (streak_q == STK_W'(MAX_STREAK));

   always_comb begin
      streak_d = streak_q;
      if (!bus.ifReq || go_if)
         streak_d = '0;
      else if (go_mem)
         streak_d = streak_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) streak_q <= '0;
      else     streak_q <= streak_d;
   end
`else
   assign fair_if = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      unique case (state_q)
         IDLE: begin
            unique case (1'b1)
               go_mem: begin
                  state_d = BUSY_MEM;
                  cnt_d   = LAT_W'(LATENCY - 1);
                  addr_d  = bus.memAddr;
                  wdata_d = bus.memWdata;
                  we_d    = bus.memWrite;
               end
               go_if: begin
                  state_d = BUSY_IF;
                  cnt_d   = LAT_W'(LATENCY - 1);
                  addr_d  = bus.ifAddr;
                  we_d    = 1'b0;
               end
               default: ;
            endcase
         end
         BUSY_MEM, BUSY_IF: begin
            if (done) state_d = IDLE;
            else      cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   // live masks the input-driven outputs while rst is high
   assign live     = ~rst;
   assign busy_mem = live & (state_q == BUSY_MEM);
   assign busy_if  = live & (state_q == BUSY_IF);
   assign mem_ack  = busy_mem & done;
   assign if_ack   = busy_if & done;

   assign bus.ramEn    = busy_mem | busy_if;
   assign bus.ramWe    = busy_mem & we_q;
   assign bus.ramAddr  = addr_q;
   assign bus.ramWdata = wdata_q;

   assign bus.memAck   = mem_ack;
   assign bus.ifAck    = if_ack;
   assign bus.memRdata = (mem_ack & ~we_q) ?
                         bus.ramRdata : '0;
   assign bus.ifRdata  = if_ack ? bus.ramRdata : '0;

   assign pipe_hold = live & mem_req & ~mem_ack;
   assign if_wait   = live & bus.ifReq & ~if_ack;

   assign bus.pipeHOLD    = pipe_hold;
   assign bus.pcHOLD      = pipe_hold | if_wait;
   assign bus.IFIDRegHOLD = pipe_hold | if_wait;
   assign bus.IFflush     = if_wait & ~pipe_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int MAXS = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32)) ba ();
   mem_port_arbiter_if #(.ADDR_W(32)) bb ();

   mem_port_arbiter #(
      .LATENCY(LAT), .LAT_W(3),
      .ADDR_W(32), .MAX_STREAK(MAXS)
   ) u_a (
      .clk(clk), .rst(rst), .bus(ba)
   );

   mem_port_arbiter #(
      .LATENCY(1), .LAT_W(3),
      .ADDR_W(32), .MAX_STREAK(MAXS)
   ) u_b (
      .clk(clk), .rst(rst), .bus(bb)
   );

   typedef struct packed {
      logic        en;
      logic        we;
      logic [31:0] ra;
      logic [31:0] wd;
      logic        ia;
      logic [31:0] ird;
      logic        mk;
      logic [31:0] mrd;
      logic        pc;
      logic        ifid;
      logic        fl;
      logic        ph;
   } outs_t;

   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        mr;
      logic        mw;
      logic [31:0] ma;
      logic [31:0] md;
      logic [31:0] rd;
      outs_t       e;
   } vec_t;

   int total  = 0;
   int passed = 0;

   int          mn, mgt, mat, mstreak;
   bit          mkm, mwe;
   logic [31:0] maddr, mwd;

   vec_t v[$];

   function automatic outs_t get_a();
      outs_t o;
      o = {ba.ramEn, ba.ramWe, ba.ramAddr, ba.ramWdata,
           ba.ifAck, ba.ifRdata, ba.memAck, ba.memRdata,
           ba.pcHOLD, ba.IFIDRegHOLD, ba.IFflush, ba.pipeHOLD};
      return o;
   endfunction

   function automatic vec_t mk(
      input logic ifr, input logic [31:0] ifa,
      input logic mr, mw,
      input logic [31:0] ma, md, rd,
      input logic en, we,
      input logic [31:0] ra, wd,
      input logic ia, input logic [31:0] ird,
      input logic mack, input logic [31:0] mrd,
      input logic pc, fl, ph);
      vec_t t;
      t.ifr = ifr; t.ifa = ifa;
      t.mr = mr; t.mw = mw;
      t.ma = ma; t.md = md; t.rd = rd;
      t.e = {en, we, ra, wd, ia, ird, mack, mrd, pc, pc, fl, ph};
      return t;
   endfunction

   task automatic chk(input string nm, input outs_t got, input outs_t exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, got, exp);
   endtask

   task automatic chkb(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, got, exp);
   endtask

   task automatic drive_a(
      input logic ifr, input logic [31:0] ifa,
      input logic mr, mw,
      input logic [31:0] ma, md, rd);
      ba.ifReq = ifr; ba.ifAddr = ifa;
      ba.memRead = mr; ba.memWrite = mw;
      ba.memAddr = ma; ba.memWdata = md;
      ba.ramRdata = rd;
   endtask

   // One cycle against the model: an access granted in cycle g
   // occupies the RAM in cycles g+1..g+LAT and acks in g+LAT.
   task automatic mstep(
      input logic r, ifr, input logic [31:0] ifa,
      input logic mr, mw,
      input logic [31:0] ma, md, rd);
      outs_t e;
      bit busy, ack, mreq, ifw, fair, gm, gi;
      rst = r;
      drive_a(ifr, ifa, mr, mw, ma, md, rd);
      @(negedge clk);
      e = '0;
      gm = 0; gi = 0; fair = 0;
      if (r) begin
         chk($sformatf("rand_rst%0d", mn), get_a(), e);
         mgt = -1; mat = -1;
         maddr = '0; mwd = '0;
         mkm = 0; mwe = 0; mstreak = 0;
      end else begin
         busy  = (mn > mgt) && (mn <= mat);
         ack   = busy && (mn == mat);
         mreq  = mr | mw;
         e.en  = busy;
         e.we  = busy && mkm && mwe;
         e.ra  = maddr;
         e.wd  = mwd;
         e.ia  = ack && !mkm;
         e.ird = e.ia ? rd : '0;
         e.mk  = ack && mkm;
         e.mrd = (e.mk && !mwe) ? rd : '0;
         e.ph  = mreq && !e.mk;
         ifw   = ifr && !e.ia;
         e.pc  = e.ph || ifw;
         e.ifid = e.pc;
         e.fl  = ifw && !e.ph;
         chk($sformatf("rand%0d", mn), get_a(), e);
`ifdef MEM_ARB_FAIR_EN
         fair = ifr && (mstreak == MAXS);
`endif
         if (!busy) begin
            if (mreq && !fair) begin
               mkm = 1; mwe = mw;
               maddr = ma; mwd = md;
               mgt = mn; mat = mn + LAT; gm = 1;
            end else if (ifr) begin
               mkm = 0; maddr = ifa;
               mgt = mn; mat = mn + LAT; gi = 1;
            end
         end
`ifdef MEM_ARB_FAIR_EN
         if (!ifr || gi) mstreak = 0;
         else if (gm) mstreak++;
`endif
      end
      mn++;
      @(posedge clk); #1;
   endtask

   always @(negedge clk)
      if (ba.memRead && ba.memWrite)
         $display("note: memRead and memWrite both high at %0t, treated as store",
                  $time);

   initial begin
      rst = 1'b1;
      drive_a(1, 32'h40, 1, 0, 32'h100, 32'h0, 32'h0);
      bb.ifReq = 0; bb.ifAddr = 0;
      bb.memRead = 0; bb.memWrite = 0;
      bb.memAddr = 0; bb.memWdata = 0;
      bb.ramRdata = 0;
      mn = 0; mgt = -1; mat = -1; mstreak = 0;
      mkm = 0; mwe = 0; maddr = 0; mwd = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", get_a(), '0);
      drive_a(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // fetch alone, then MEM vs IF collision, then store, then rd+wr
      v.push_back(mk(1,32'h40,0,0,0,0,32'h8C010004, 0,0,0,0, 0,0,0,0, 1,1,0));
      v.push_back(mk(1,32'h40,0,0,0,0,32'h8C010004, 1,0,32'h40,0, 0,0,0,0, 1,1,0));
      v.push_back(mk(1,32'h40,0,0,0,0,32'h8C010004, 1,0,32'h40,0, 1,32'h8C010004,0,0, 0,0,0));
      v.push_back(mk(0,32'h40,0,0,0,0,32'h8C010004, 0,0,32'h40,0, 0,0,0,0, 0,0,0));
      v.push_back(mk(1,32'h44,1,0,32'h100,0,32'h11112222, 0,0,32'h40,0, 0,0,0,0, 1,0,1));
      v.push_back(mk(1,32'h44,1,0,32'h100,0,32'h11112222, 1,0,32'h100,0, 0,0,0,0, 1,0,1));
      v.push_back(mk(1,32'h44,1,0,32'h100,0,32'h11112222, 1,0,32'h100,0, 0,0,1,32'h11112222, 1,1,0));
      v.push_back(mk(1,32'h44,0,0,32'h100,0,32'h11112222, 0,0,32'h100,0, 0,0,0,0, 1,1,0));
      v.push_back(mk(1,32'h44,0,0,32'h100,0,32'h11112222, 1,0,32'h44,0, 0,0,0,0, 1,1,0));
      v.push_back(mk(1,32'h44,0,0,32'h100,0,32'h11112222, 1,0,32'h44,0, 1,32'h11112222,0,0, 0,0,0));
      v.push_back(mk(0,32'h44,0,0,32'h100,0,32'h11112222, 0,0,32'h44,0, 0,0,0,0, 0,0,0));
      v.push_back(mk(0,0,0,1,32'h200,32'hDEADBEEF,32'h55555555, 0,0,32'h44,0, 0,0,0,0, 1,0,1));
      v.push_back(mk(0,0,0,1,32'h200,32'hDEADBEEF,32'h55555555, 1,1,32'h200,32'hDEADBEEF, 0,0,0,0, 1,0,1));
      v.push_back(mk(0,0,0,1,32'h200,32'hDEADBEEF,32'h55555555, 1,1,32'h200,32'hDEADBEEF, 0,0,1,0, 0,0,0));
      v.push_back(mk(0,0,0,0,32'h200,32'hDEADBEEF,0, 0,0,32'h200,32'hDEADBEEF, 0,0,0,0, 0,0,0));
      v.push_back(mk(0,0,1,1,32'h300,32'h12345678,0, 0,0,32'h200,32'hDEADBEEF, 0,0,0,0, 1,0,1));
      v.push_back(mk(0,0,1,1,32'h300,32'h12345678,0, 1,1,32'h300,32'h12345678, 0,0,0,0, 1,0,1));
      v.push_back(mk(0,0,1,1,32'h300,32'h12345678,0, 1,1,32'h300,32'h12345678, 0,0,1,0, 0,0,0));
      v.push_back(mk(0,0,0,0,0,0,0, 0,0,32'h300,32'h12345678, 0,0,0,0, 0,0,0));

      for (int i = 0; i < v.size(); i++) begin
         drive_a(v[i].ifr, v[i].ifa, v[i].mr, v[i].mw,
                 v[i].ma, v[i].md, v[i].rd);
         @(negedge clk);
         chk($sformatf("vec%0d", i), get_a(), v[i].e);
         @(posedge clk); #1;
      end

      // reset in the first BUSY_MEM cycle aborts the load
      drive_a(0, 0, 1, 0, 32'h80, 0, 32'hA5A5A5A5);
      @(negedge clk);
      chkb("rst_grant_hold", ba.pipeHOLD, 1);
      @(posedge clk); #1;
      chkb("rst_busy_en", ba.ramEn, 1);
      rst = 1'b1; #1;
      chk("rst_mid_outs", get_a(), '0);
      #1 rst = 1'b0;
      @(negedge clk);
      chkb("rst_idle_en", ba.ramEn, 0);
      chkb("rst_no_ack", ba.memAck, 0);
      chkb("rst_regrant_hold", ba.pipeHOLD, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chkb("rst_a1_en", ba.ramEn, 1);
      chkb("rst_a1_ack", ba.memAck, 0);
      chkb("rst_a1_addr", ba.ramAddr, 32'h80);
      @(posedge clk); #1;
      @(negedge clk);
      chkb("rst_a2_ack", ba.memAck, 1);
      chkb("rst_a2_rdata", ba.memRdata, 32'hA5A5A5A5);
      @(posedge clk); #1;
      drive_a(0, 0, 0, 0, 0, 0, 0);

      // LATENCY=1: back-to-back loads with one IDLE cycle between
      bb.memRead = 1; bb.memAddr = 32'hA0;
      bb.ramRdata = 32'h0BADF00D;
      @(negedge clk);
      chkb("l1_g0_ack", bb.memAck, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chkb("l1_a0_ack", bb.memAck, 1);
      chkb("l1_a0_addr", bb.ramAddr, 32'hA0);
      chkb("l1_a0_rdata", bb.memRdata, 32'h0BADF00D);
      @(posedge clk); #1;
      bb.memAddr = 32'hA4;
      @(negedge clk);
      chkb("l1_gap_en", bb.ramEn, 0);
      chkb("l1_gap_ack", bb.memAck, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chkb("l1_a1_ack", bb.memAck, 1);
      chkb("l1_a1_addr", bb.ramAddr, 32'hA4);
      @(posedge clk); #1;
      bb.memRead = 0;

      // model-checked traffic: held contention, then random
      mstep(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++)
         mstep(0, 1, 32'h1000 + 4 * i, 1, 0,
               32'h2000 + 4 * i, 0, $urandom);
      for (int i = 0; i < 800; i++) begin
         int sel;
         sel = $urandom_range(0, 2);
         mstep($urandom_range(0, 99) == 0,
               $urandom_range(0, 1), $urandom,
               sel == 1, sel == 2,
               $urandom, $urandom, $urandom);
      end
      mstep(0, 0, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
